// File: rtl/tpu_pkg.sv
// Shared constants and types for the systolic-array datapath blocks.
// Sum lane width, operand width and the result-drain FSM state encoding.
package tpu_pkg;

   localparam int SUM_W  = 16;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } drain_state_t;

endpackage

// File: rtl/sys_arr_drain_if.sv
// Result-row delivery handshake from the array drain to the unified-buffer writer.
// Row data and address are held stable by the master while valid is high and ready is low.
interface sys_arr_drain_if
   import tpu_pkg::*;
#(
   parameter int width_height = 2,
   parameter int ADDR_W       = 8
);

   logic                           out_valid;
   logic                           out_ready;
   logic [SUM_W*width_height-1:0]  out_data;
   logic [ADDR_W-1:0]              out_addr;

   modport master (
      output out_valid,
      output out_data,
      output out_addr,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_addr,
      output out_ready
   );

endinterface

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only with a same-cycle pop.
// Output reads as zero while empty so nothing stale is ever presented.
module result_fifo #(
   parameter int width = 32,
   parameter int depth = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [width-1:0]            din,
   input  logic                        pop,
   output logic [width-1:0]            dout,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(depth):0]      cnt
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [width-1:0] mem [depth];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full  = (cnt == CW'(depth));
   assign empty = (cnt == '0);
   assign do_rd = pop && !empty;
   assign do_wr = push && (!full || do_rd);
   assign dout  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: every read of it is gated by the count.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sys_arr_drain.sv
// Deskews the array bottom-row sums into aligned rows, buffers them and hands them off with sequential addresses.
// Row pushed width_height-1 cycles after its column-0 flag; delivery stalls on out_ready, full FIFO drops rows.
module sys_arr_drain
   import tpu_pkg::*;
#(
   parameter int width_height = 2,
   parameter int ADDR_W       = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [SUM_W*width_height-1:0]  maccout,
   input  logic [width_height-1:0]        activeout,
   input  logic                           start,
   input  logic [ADDR_W-1:0]              base_addr,
   input  logic [ADDR_W-1:0]              num_rows,
   sys_arr_drain_if.master                dr,
   output logic                           busy,
   output logic                           done,
   output logic                           overflow_err,
   output logic                           skew_err
);

   localparam int ROW_W = SUM_W * width_height;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   drain_state_t       state;
   logic [ADDR_W-1:0]  base_q;
   logic [ADDR_W-1:0]  num_q;
   logic [ADDR_W-1:0]  wr_cnt;
   logic [ADDR_W-1:0]  wr_inc;
   logic [ADDR_W-1:0]  pop_cnt;

   logic [ROW_W-1:0]        row_data;
   logic [width_height-1:0] row_act;
   logic                    row_valid;
   logic                    row_mix;

   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_cnt;
   logic [ROW_W-1:0] fifo_dout;

   // Column c arrives c cycles after column 0, so it is delayed by the remaining width_height-1-c.
   for (genvar c = 0; c < width_height; c++) begin : g_col
      localparam int D = width_height - 1 - c;
      if (D == 0) begin : g_pass
         assign row_data[c*SUM_W +: SUM_W] = maccout[c*SUM_W +: SUM_W];
         assign row_act[c]                 = activeout[c];
      end else begin : g_dly
         logic [SUM_W-1:0] sum_sr [D];
         logic             act_sr [D];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < D; i++) begin
                  sum_sr[i] <= '0;
                  act_sr[i] <= 1'b0;
               end
            end else begin
               sum_sr[0] <= maccout[c*SUM_W +: SUM_W];
               act_sr[0] <= activeout[c];
               for (int i = 1; i < D; i++) begin
                  sum_sr[i] <= sum_sr[i-1];
                  act_sr[i] <= act_sr[i-1];
               end
            end
         end
         assign row_data[c*SUM_W +: SUM_W] = sum_sr[D-1];
         assign row_act[c]                 = act_sr[D-1];
      end
   end

   assign row_valid = &row_act;
   assign row_mix   = (|row_act) && !row_valid;
   assign wr_inc    = wr_cnt + ADDR_W'(1);

   assign fifo_pop  = !fifo_empty && dr.out_ready;
   assign fifo_push = (state == COLLECT) && row_valid && (!fifo_full || fifo_pop);

   result_fifo #(
      .width (ROW_W),
      .depth (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (row_data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .cnt   (fifo_cnt)
   );

   assign dr.out_valid = !fifo_empty;
   assign dr.out_data  = fifo_dout;
   assign dr.out_addr  = base_q + pop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         base_q       <= '0;
         num_q        <= '0;
         wr_cnt       <= '0;
         pop_cnt      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         overflow_err <= 1'b0;
         skew_err     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fifo_pop) pop_cnt <= pop_cnt + ADDR_W'(1);
         if (row_mix)  skew_err <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  base_q       <= base_addr;
                  num_q        <= num_rows;
                  wr_cnt       <= '0;
                  pop_cnt      <= '0;
                  overflow_err <= 1'b0;
                  skew_err     <= 1'b0;
                  if (num_rows == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= COLLECT;
                     busy  <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               // A dropped row still counts, so collection always ends after num_rows rows.
               if (row_valid) begin
                  wr_cnt <= wr_inc;
                  if (fifo_full && !fifo_pop) overflow_err <= 1'b1;
                  if (wr_inc == num_q) state <= DRAIN;
               end
            end
            DRAIN: begin
               // Leave on the edge of the final pop so done lands one cycle after it.
               if (fifo_empty || (fifo_pop && fifo_cnt == CW'(1))) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
